// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
// Receive end of a framed serial link. Serial bits on SI, qualified by VI,
// are assembled LSB first into WIDTH-bit words. Each completed word is
// handed to a one-entry output buffer (PO/OK) that the consumer drains
// with ack. The next word can be shifted in while the buffer is still
// waiting for ack.
//
// Ports
//   ck     in   clock; all state updates on the rising edge
//   reset  in   synchronous, active-high reset
//   VI     in   serial valid; high for WIDTH consecutive cycles per word
//   SI     in   serial data; sampled only when VI=1
//   ack    in   consumer accepts PO; effective only when OK=1
//   PO     out  received parallel word (held output buffer)
//   OK     out  PO holds an unacknowledged word
//   busy   out  word reception in progress
//   cnt    out  index of the next bit to be captured
//   err    out  one-cycle pulse: VI dropped mid-word, partial word discarded
//   ovr    out  one-cycle pulse: word completed while buffer full, word dropped

module serial_to_parallel_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     ck,
    input  logic                     reset,
    input  logic                     VI,
    input  logic                     SI,
    input  logic                     ack,
    output logic [WIDTH-1:0]         PO,
    output logic                     OK,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     err,
    output logic                     ovr
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] word_c;

    // Full word as it stands on the completing edge: last bit comes straight from SI.
    assign word_c = {SI, shift[WIDTH-2:0]};

    // busy is decoded from the state register, so it carries no combinational input path.
    assign busy = (state == RECV);

    // Receive FSM, shift register and output buffer.
    always_ff @(posedge ck) begin
        if (reset) begin
            state <= IDLE;
            shift <= '0;
            PO    <= '0;
            OK    <= 1'b0;
            cnt   <= '0;
            err   <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            err <= 1'b0;
            ovr <= 1'b0;

            // Plain ack drains the buffer; a same-cycle completion below overrides this.
            if (OK && ack) begin
                OK <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (VI) begin
                        shift <= WIDTH'(SI);
                        cnt   <= CNT_W'(1);
                        state <= RECV;
                    end
                end

                RECV: begin
                    if (!VI) begin
                        // Framing error: drop the partial word, leave the buffer alone.
                        err   <= 1'b1;
                        shift <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == LAST_IDX) begin
                        shift <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                        // Buffer is free if empty or being acked in this same cycle.
                        if (!OK || ack) begin
                            PO <= word_c;
                            OK <= 1'b1;
                        end else begin
                            ovr <= 1'b1;
                        end
                    end else begin
                        shift[cnt] <= SI;
                        cnt        <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Directed bench for serial_to_parallel_rx (WIDTH=8). Inputs change 1 ns
// after each rising edge; outputs are checked at that same point.

module tb_serial_to_parallel_rx;

    localparam int unsigned WIDTH = 8;

    logic             ck;
    logic             reset;
    logic             VI;
    logic             SI;
    logic             ack;
    logic [WIDTH-1:0] PO;
    logic             OK;
    logic             busy;
    logic [2:0]       cnt;
    logic             err;
    logic             ovr;

    int n_checks;
    int n_fail;

    serial_to_parallel_rx #(.WIDTH(WIDTH)) dut (
        .ck   (ck),
        .reset(reset),
        .VI   (VI),
        .SI   (SI),
        .ack  (ack),
        .PO   (PO),
        .OK   (OK),
        .busy (busy),
        .cnt  (cnt),
        .err  (err),
        .ovr  (ovr)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_po, input logic e_ok,
                           input logic e_busy, input logic [2:0] e_cnt,
                           input logic e_err, input logic e_ovr);
        chk({tag, ".PO"},   32'(PO),   32'(e_po));
        chk({tag, ".OK"},   32'(OK),   32'(e_ok));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".cnt"},  32'(cnt),  32'(e_cnt));
        chk({tag, ".err"},  32'(err),  32'(e_err));
        chk({tag, ".ovr"},  32'(ovr),  32'(e_ovr));
    endtask

    // Shift a whole word LSB first; ack is raised only during the last bit if requested.
    // VI is left high on return so words can be chained without a gap.
    task automatic send_word(input string tag, input logic [7:0] w, input logic ack_last);
        for (int i = 0; i < 8; i++) begin
            VI  = 1'b1;
            SI  = w[i];
            ack = (i == 7) ? ack_last : 1'b0;
            tick();
            chk({tag, ".cnt"},  32'(cnt),  32'((i + 1) % 8));
            chk({tag, ".busy"}, 32'(busy), 32'(i < 7));
        end
        ack = 1'b0;
    endtask

    initial begin
        logic [7:0] part;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        VI    = 1'b0;
        SI    = 1'b0;
        ack   = 1'b0;

        // Reset and idle
        tick();
        tick();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("idle", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        end

        // Single word 0xA5, then ack
        send_word("a5", 8'hA5, 1'b0);
        VI = 1'b0;
        chk_all("a5_done", 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("a5_ack.OK", 32'(OK), 32'd0);

        // Back-to-back 0x3C then 0xC3, ack in 0xC3's completion cycle
        send_word("3c", 8'h3C, 1'b0);
        chk_all("3c_done", 8'h3C, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        send_word("c3", 8'hC3, 1'b1);
        VI = 1'b0;
        chk_all("c3_done", 8'hC3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("c3_ack.OK", 32'(OK), 32'd0);

        // Overrun: 0x11 held, 0x22 dropped
        send_word("11", 8'h11, 1'b0);
        VI = 1'b0;
        tick();
        chk_all("11_held", 8'h11, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        send_word("22", 8'h22, 1'b0);
        VI = 1'b0;
        chk_all("ovr_pulse", 8'h11, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        chk_all("ovr_clear", 8'h11, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // Framing error with a held word: 4 bits then VI drops
        part = 8'h0F;
        for (int i = 0; i < 4; i++) begin
            VI = 1'b1;
            SI = part[i];
            tick();
        end
        chk("frame_pre.cnt", 32'(cnt), 32'd4);
        VI = 1'b0;
        tick();
        chk_all("frame_err", 8'h11, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        chk_all("frame_clear", 8'h11, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("11_ack.OK", 32'(OK), 32'd0);
        send_word("5a", 8'h5A, 1'b0);
        VI = 1'b0;
        chk_all("5a_done", 8'h5A, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Reset mid-word while 0x77 is held
        send_word("77", 8'h77, 1'b0);
        VI = 1'b0;
        chk_all("77_done", 8'h77, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            VI = 1'b1;
            SI = 1'b1;
            tick();
        end
        chk("mid_pre.cnt", 32'(cnt), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all("mid_reset", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            VI = 1'b1;
            SI = 1'b1;
            tick();
            chk_all("post_reset", 8'h00, 1'b0, 1'b1, 3'(i + 1), 1'b0, 1'b0);
        end
        VI = 1'b0;
        tick();
        chk_all("post_reset_drop", 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
Receive end of the parallel-to-serial link: deserialises a framed serial bit stream (SI qualified by VI) into WIDTH-bit parallel words, LSB first.
- Bit k of a word arrives in the k-th valid cycle, matching the transmit controller's sel count order 0..WIDTH-1.
- Completed words are held in an output buffer with a valid/ack handshake toward the consumer.
- A new word can be shifted in while the previous one waits for ack.

Parameters:
WIDTH, 8, word width in bits; 2..32. The bit-counter width is derived internally as clog2(WIDTH).

Ports:
ck  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
VI  input  1  serial valid from transmitter; high for WIDTH consecutive cycles per word
SI  input  1  serial data; sampled only when VI=1
ack  input  1  consumer accepts PO; effective only when OK=1
PO  output  WIDTH  received parallel word (held output buffer)
OK  output  1  PO holds an unacknowledged word
busy  output  1  word reception in progress (state RECV)
cnt  output  clog2(WIDTH)  index of the next bit to be captured
err  output  1  one-cycle pulse: VI dropped mid-word, partial word discarded
ovr  output  1  one-cycle pulse: word completed while buffer full, new word dropped

Behaviour:
Reset
- Synchronous: on a rising ck edge with reset=1, all state clears.
- State=IDLE; shift register=0; PO=0; OK=0; busy=0; cnt=0; err=0; ovr=0.
- Reset overrides every other input, including mid-word and while OK=1; any partial or held word is lost.

Receive FSM (states IDLE, RECV)
- IDLE, VI=1:
  - Capture SI into shift[0]; cnt<=1; go to RECV.
- IDLE, VI=0: hold; cnt stays 0.
- RECV, VI=1, cnt<WIDTH-1:
  - Capture SI into shift[cnt]; cnt<=cnt+1.
- RECV, VI=1, cnt=WIDTH-1 (word complete):
  - Capture last bit; cnt<=0; go to IDLE.
  - Hand the full word to the output buffer (see below).
- RECV, VI=0 (framing error):
  - err=1 for exactly one cycle; shift register cleared; cnt<=0; go to IDLE.
  - PO and OK are unaffected.
- busy=1 exactly while in RECV.
- Back-to-back words with no VI gap are supported. A word that completes on edge t returns the FSM to IDLE; if VI=1 on edge t+1, that edge starts the next word.

Output buffer
- Word completes on edge t with OK=0, or with OK=1 and ack=1 in the same cycle:
  - PO<=completed word (including the last bit sampled at edge t).
  - OK=1 after edge t, i.e. latency of 0 cycles after the last bit is sampled.
- Word completes with OK=1 and ack=0:
  - ovr=1 for one cycle; the new word is dropped; PO and OK are unchanged.
- ack=1 with OK=1 and no completion: OK<=0 next edge; PO retains its value, which is don't-care for the consumer.
- ack=1 with OK=0: ignored.
- PO stays stable for as long as OK=1.
- err and ovr never assert in the same cycle. They are registered pulses, high for the single cycle following the causing edge.

Arithmetic and widths
- cnt counts 0..WIDTH-1; it never reaches WIDTH and wraps only through the completion path.
- For non-power-of-2 WIDTH, counter values >= WIDTH are unreachable.

Test Plan:
- Reset and idle: reset=1 for 2 cycles, then VI=0 for 5 cycles -> PO=0x00, OK=0, busy=0, cnt=0, err=0, ovr=0 throughout.
- Single word: VI=1 for 8 cycles with SI=1,0,1,0,0,1,0,1 (0xA5, LSB first) -> busy=1 during cycles 2..8, cnt steps 1..7 then 0, OK=1 with PO=0xA5 after the 8th edge; ack=1 one cycle later -> OK=0 next edge.
- Back-to-back with same-cycle ack: send 0x3C, then immediately 0xC3 with no VI gap. Hold ack=0 until the 0xC3 completion cycle, then ack=1 in that cycle -> PO switches 0x3C to 0xC3, OK stays 1, ovr=0.
- Overrun: receive 0x11, leave ack=0, send 0x22 -> ovr pulses for exactly 1 cycle after 0x22's last edge; PO=0x11, OK=1 unchanged.
- Framing error: VI=1 for 4 bits, then VI=0 -> err=1 for one cycle, cnt=0, busy=0, OK unchanged. A following full word 0x5A is received correctly.
- Reset mid-operation: assert reset after 5 bits of a word while OK=1 holding 0x77 -> next edge PO=0x00, OK=0, cnt=0, busy=0. The remaining 3 bits with VI=1 after reset start a new word (cnt=1,2,3) and produce no OK.
